// File: rtl/cdc_xfer_arbiter.sv
// Round-robin sequencer in front of a shared four-phase req/ack crossing.
// The outgoing word and source index stay frozen for the whole handshake.

module async_ff #(
   parameter int DW = 1
) (
   input  logic          CP,
   input  logic          CLR,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   always_ff @(posedge CP or posedge CLR) begin
      if (CLR) q <= '0;
      else     q <= d;
   end
endmodule

module cdc_xfer_arbiter #(
   parameter int N           = 4,
   parameter int DW          = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic                 CP,
   input  logic                 CLR,
   input  logic [N-1:0]         req_valid,
   input  logic [N*DW-1:0]      req_data,
   output logic [N-1:0]         req_ready,
   output logic                 xfer_req,
   output logic [DW-1:0]        xfer_data,
   output logic [$clog2(N)-1:0] xfer_src,
   input  logic                 xfer_ack,
   output logic                 done,
   output logic                 busy,
   output logic                 timeout
);
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t        state, state_n;
   logic [PW-1:0] ptr, gnt_idx, scan;
   logic          gnt_found, grant, ack_s;
   logic [CW-1:0] stall;
   logic          ack_chain [0:SYNC_STAGES];

   assign ack_chain[0] = xfer_ack;
   for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
      async_ff #(.DW(1)) u_ff (
         .CP  (CP),
         .CLR (CLR),
         .d   (ack_chain[s]),
         .q   (ack_chain[s+1])
      );
   end
   assign ack_s = ack_chain[SYNC_STAGES];

   // First valid requester at or after ptr, wrapping modulo N.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int i = 0; i < N; i++) begin
         scan = PW'((int'(ptr) + i) % N);
         if (!gnt_found && req_valid[scan]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan;
         end
      end
   end

   always_ff @(posedge CP or posedge CLR) begin
      if (CLR) state <= IDLE;
      else     state <= state_n;
   end

   // A still-high synchronized ack in IDLE is stale: hold off until it drops.
   always_comb begin
      state_n   = state;
      grant     = 1'b0;
      req_ready = '0;
      case (state)
         IDLE: if (gnt_found && !ack_s) begin
            grant              = 1'b1;
            state_n            = REQ;
            req_ready[gnt_idx] = ~CLR;
         end
         REQ:     if (ack_s)  state_n = REL;
         REL:     if (!ack_s) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge CP or posedge CLR) begin
      if (CLR) begin
         xfer_req  <= 1'b0;
         xfer_data <= '0;
         xfer_src  <= '0;
         ptr       <= '0;
         done      <= 1'b0;
         stall     <= '0;
         timeout   <= 1'b0;
      end else begin
         xfer_req <= (state_n == REQ);
         done     <= (state == REL) && (state_n == IDLE);
         if (grant) begin
            xfer_data <= req_data[int'(gnt_idx)*DW +: DW];
            xfer_src  <= gnt_idx;
            ptr       <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
         end
         // Saturating stall count; the handshake itself is never abandoned.
         if (state_n != state)
            stall <= '0;
         else if (busy && stall != CW'(TIMEOUT-1))
            stall <= stall + 1'b1;
         if (busy && stall == CW'(TIMEOUT-1))
            timeout <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Randomized scoreboard bench for cdc_xfer_arbiter with a transaction-level
// round-robin model and a delayed-echo destination model.

module tb_cdc_xfer_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;

   logic            CP, CLR;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*DW-1:0] req_data;
   logic            xfer_req, xfer_ack, done, busy, timeout;
   logic [DW-1:0]   xfer_data;
   logic [1:0]      xfer_src;

   typedef struct {
      int            src;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb_q[$];
   int            n_cmp, n_bad;
   logic [N-1:0]  pend;
   logic [DW-1:0] pdata [N];
   int            m_ptr;
   logic [7:0]    hist;
   int            ack_dly;
   bit            ack_force, rand_dly;

   cdc_xfer_arbiter #(.N(N), .DW(DW), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
      .CP        (CP),
      .CLR       (CLR),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .xfer_req  (xfer_req),
      .xfer_data (xfer_data),
      .xfer_src  (xfer_src),
      .xfer_ack  (xfer_ack),
      .done      (done),
      .busy      (busy),
      .timeout   (timeout)
   );

   initial begin
      CP = 1'b0;
      forever #5 CP = ~CP;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Destination domain: echoes xfer_req ack_dly cycles later.
   initial begin
      hist = '0;
      forever begin
         @(posedge CP); #1;
         if (CLR) hist = '0;
         else     hist = {hist[6:0], xfer_req};
         if (rand_dly && hist[6:0] == '0) ack_dly = $urandom_range(3, 6);
         if (!ack_force) xfer_ack = hist[ack_dly];
      end
   end

   // Monitor: every new handshake must carry the oldest expected word.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge CP);
         if (xfer_req && !prev) begin
            check("sb_expected_xfer", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("sb_src", xfer_src, e.src);
               check("sb_data", xfer_data, e.data);
            end
         end
         prev = xfer_req;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pick();
      for (int i = 0; i < N; i++)
         if (pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return 0;
   endfunction

   task automatic drive();
      req_valid = pend;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
   endtask

   // Predicts the next grant, waits for it, then retires (or refills) that requester.
   task automatic expect_grant(input bit want_done, input bit refill, output int lat);
      int   g, w;
      exp_t e;
      g      = pick();
      e.src  = g;
      e.data = pdata[g];
      sb_q.push_back(e);
      w = 0;
      @(negedge CP);
      while (req_ready == '0 && w < 300) begin
         @(negedge CP);
         w++;
      end
      check("grant_onehot", req_ready, 64'(1) << g);
      if (want_done) check("done_with_grant", done, 1);
      lat   = w;
      m_ptr = (g + 1) % N;
      @(posedge CP); #1;
      if (refill) pdata[g] = $urandom;
      else        pend[g]  = 1'b0;
      drive();
   endtask

   task automatic do_reset();
      @(posedge CP); #1;
      CLR = 1'b1; xfer_ack = 1'b0; ack_force = 1'b0; pend = '0; m_ptr = 0;
      drive();
      repeat (2) @(posedge CP);
      #1 CLR = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge CP);
      while (busy && w < 300) begin
         @(negedge CP);
         w++;
      end
      check("idle_reached", busy, 0);
   endtask

   initial begin
      int         lat, w;
      logic [3:0] newm;
      n_cmp = 0; n_bad = 0;
      ack_dly = 3; ack_force = 1'b0; rand_dly = 1'b0;
      CLR = 1'b1; xfer_ack = 1'b0; pend = '0; m_ptr = 0;
      for (int i = 0; i < N; i++) pdata[i] = '0;
      drive();
      #1;
      check("rst_xfer_req", xfer_req, 0);
      check("rst_xfer_data", xfer_data, 0);
      check("rst_xfer_src", xfer_src, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      check("rst_req_ready", req_ready, 0);
      do_reset();

      // Single request with 3-cycle echo: exact cycle timeline.
      @(posedge CP); #1;
      pend = 4'b0010; pdata[1] = 32'hDEADBEEF; drive();
      expect_grant(0, 0, lat);
      check("t1_lat", lat, 0);
      for (int c = 1; c <= 14; c++) begin
         @(negedge CP);
         check($sformatf("t1_req_c%0d", c), xfer_req, (c <= 6));
         check($sformatf("t1_busy_c%0d", c), busy, (c <= 12));
         check($sformatf("t1_done_c%0d", c), done, (c == 13));
         if (c == 1) begin
            check("t1_data", xfer_data, 32'hDEADBEEF);
            check("t1_src", xfer_src, 1);
         end
      end

      // Round robin with all requesters held.
      do_reset();
      @(posedge CP); #1;
      pend = 4'b1111;
      for (int i = 0; i < N; i++) pdata[i] = 32'hA5A5_0000 + i;
      drive();
      for (int k = 0; k < 5; k++) expect_grant(k > 0, 1, lat);
      pend = '0; drive();
      wait_idle();

      // Pointer fairness.
      do_reset();
      @(posedge CP); #1;
      pend = 4'b0100; pdata[2] = 32'h2222_0001; drive();
      expect_grant(0, 0, lat);
      pend[0] = 1'b1; pdata[0] = 32'h0000_0BAD; pend[2] = 1'b1; pdata[2] = 32'h2222_0002;
      drive();
      expect_grant(1, 0, lat);
      expect_grant(1, 0, lat);
      wait_idle();

      // Stale acknowledge held in IDLE.
      do_reset();
      @(posedge CP); #1;
      ack_force = 1'b1; xfer_ack = 1'b1;
      repeat (3) @(posedge CP);
      #1 pend = 4'b0001; pdata[0] = 32'h5747_0A11; drive();
      for (int c = 0; c < 4; c++) begin
         @(negedge CP);
         check("stale_no_grant", req_ready, 0);
      end
      @(posedge CP); #1;
      xfer_ack = 1'b0; ack_force = 1'b0;
      @(negedge CP); check("stale_rel_c0", req_ready, 0);
      @(negedge CP); check("stale_rel_c1", req_ready, 0);
      expect_grant(0, 0, lat);
      check("stale_rel_lat", lat, 0);
      wait_idle();

      // Timeout: ack withheld, then released late.
      do_reset();
      @(posedge CP); #1;
      ack_force = 1'b1; xfer_ack = 1'b0;
      pend = 4'b0001; pdata[0] = 32'h7100_0001; drive();
      expect_grant(0, 0, lat);
      for (int c = 1; c <= 65; c++) begin
         @(negedge CP);
         if (c == 64) check("to_not_yet", timeout, 0);
         if (c == 65) begin
            check("to_set", timeout, 1);
            check("to_req_held", xfer_req, 1);
         end
      end
      @(posedge CP); #1 ack_force = 1'b0;
      w = 0;
      do begin
         @(negedge CP);
         w++;
      end while (!done && w < 200);
      check("to_done_seen", done, 1);
      check("to_sticky", timeout, 1);

      // Asynchronous reset in the middle of REQ.
      do_reset();
      @(posedge CP); #1;
      pend = 4'b0010; pdata[1] = 32'hC0FF_EE01; drive();
      expect_grant(0, 0, lat);
      @(negedge CP);
      check("mid_pre_req", xfer_req, 1);
      #2 CLR = 1'b1; xfer_ack = 1'b0; m_ptr = 0;
      #1;
      check("mid_req", xfer_req, 0);
      check("mid_data", xfer_data, 0);
      check("mid_src", xfer_src, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_timeout", timeout, 0);
      check("mid_ready", req_ready, 0);
      repeat (2) @(posedge CP);
      #1 CLR = 1'b0;
      pend = 4'b1000; pdata[3] = 32'h3333_0003; drive();
      expect_grant(0, 0, lat);
      pend = 4'b1111;
      for (int i = 0; i < 3; i++) pdata[i] = 32'hB0B0_0000 + i;
      drive();
      for (int k = 0; k < 4; k++) expect_grant(1, 1, lat);
      pend = '0; drive();
      wait_idle();

      // Randomized traffic and destination latency.
      rand_dly = 1'b1;
      @(posedge CP); #1;
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) pdata[i] = $urandom;
      drive();
      for (int k = 0; k < 40; k++) begin
         expect_grant(k > 0, 0, lat);
         newm = 4'($urandom_range(0, 15));
         for (int i = 0; i < N; i++)
            if (newm[i] && !pend[i]) begin
               pend[i]  = 1'b1;
               pdata[i] = $urandom;
            end
         if (pend == '0) begin
            pend[k % N]  = 1'b1;
            pdata[k % N] = $urandom;
         end
         drive();
      end
      pend = '0; drive();
      wait_idle();
      repeat (3) @(negedge CP);
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
